dvi_link_sequencer: RTL and testbench



---
 rtl/dvi_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/dvi_link_sequencer.sv | 164 ++++++++++++++++
 tb/tb_dvi_link_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dvi_pkg
//  Description : Shared definitions for the DVI/TMDS output path. Holds the
//                link sequencer state encoding and the relock counter width,
//                both also decoded by the status/debug register block.
//  Revision    : 1.0 - initial release
// ============================================================================
package dvi_pkg;

    // Link sequencer state encoding (read back through the status block,
    // so the numeric values are part of the register map).
    localparam int         c_STATE_W      = 3;
    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_RESET      = 3'd1;
    localparam logic [2:0] c_ST_SETTLE     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_FRAME = 3'd3;
    localparam logic [2:0] c_ST_RUN        = 3'd4;

    // Relock event counter
    localparam int         c_RELOCK_W     = 8;
    localparam logic [c_RELOCK_W-1:0] c_RELOCK_MAX = '1;

endpackage : dvi_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous level.
//                Both flops carry ASYNC_REG so placement keeps them adjacent.
//  Ports       : i_clk  - destination clock
//                i_rst  - synchronous active-high reset (output forced low)
//                i_d    - asynchronous input level
//                o_q    - synchronized level, two destination cycles late
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic r_meta;
    (* ASYNC_REG = "TRUE" *) logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/dvi_link_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dvi_link_sequencer
//  Description : Bring-up / recovery sequencer for the DVI TMDS output path.
//                Qualifies MMCM lock, holds the OSERDES in reset, releases
//                them, blanks for a settle period and enables video on a
//                frame boundary. Lock loss or disable drops back to IDLE.
//  Ports       : i_clk          - pixel clock (serializer CLKDIV)
//                i_rst          - synchronous active-high reset
//                i_mmcm_locked  - MMCM lock, asynchronous
//                i_enable       - link enable request
//                i_frame_start  - one-cycle start-of-frame pulse
//                o_rst_oserdes  - serializer reset, active high
//                o_tx_enable    - 1: video/data, 0: control tokens
//                o_link_up      - link in RUN
//                o_relock_count - saturating count of lock-loss exits from RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module dvi_link_sequencer
    import dvi_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int SETTLE_CYCLES      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mmcm_locked,
    input  logic                  i_enable,
    input  logic                  i_frame_start,
    output logic                  o_rst_oserdes,
    output logic                  o_tx_enable,
    output logic                  o_link_up,
    output logic [c_RELOCK_W-1:0] o_relock_count
);

    localparam int c_STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int c_HOLD_W   = $clog2(RST_HOLD_CYCLES + 1);
    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_STABLE_W-1:0] c_STABLE_MAX = c_STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST  = c_HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);

    logic                  w_lock_s;
    logic                  w_abort;

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STABLE_W-1:0] r_stable_cnt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic                  r_rst_oserdes;
    logic                  r_tx_enable;
    logic                  r_link_up;
    logic [c_RELOCK_W-1:0] r_relock_count;

    // ------------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------------
    sync_2ff u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_mmcm_locked),
        .o_q   (w_lock_s)
    );

    // Lock loss outranks disable; both only matter once the link has left
    // IDLE (IDLE already holds the serializers in reset).
    assign w_abort = (r_state != c_ST_IDLE) && (!w_lock_s || !i_enable);

    // ------------------------------------------------------------------------
    // Sequencer: state, cycle counters and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= c_ST_IDLE;
            r_stable_cnt   <= '0;
            r_hold_cnt     <= '0;
            r_settle_cnt   <= '0;
            r_rst_oserdes  <= 1'b1;
            r_tx_enable    <= 1'b0;
            r_link_up      <= 1'b0;
            r_relock_count <= '0;
        end else begin
            // Lock qualification runs in every state; any abort below
            // overrides it so re-entry always re-qualifies from zero.
            if (!w_lock_s) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt != c_STABLE_MAX) begin
                r_stable_cnt <= r_stable_cnt + 1'b1;
            end

            if (w_abort) begin
                r_state       <= c_ST_IDLE;
                r_stable_cnt  <= '0;
                r_rst_oserdes <= 1'b1;
                r_tx_enable   <= 1'b0;
                r_link_up     <= 1'b0;
                if (r_state == c_ST_RUN && !w_lock_s &&
                    r_relock_count != c_RELOCK_MAX) begin
                    r_relock_count <= r_relock_count + 1'b1;
                end
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_rst_oserdes <= 1'b1;
                        r_tx_enable   <= 1'b0;
                        r_link_up     <= 1'b0;
                        if (r_stable_cnt == c_STABLE_MAX && i_enable) begin
                            r_state    <= c_ST_RESET;
                            r_hold_cnt <= '0;
                        end
                    end

                    c_ST_RESET: begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state       <= c_ST_SETTLE;
                            r_settle_cnt  <= '0;
                            r_rst_oserdes <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end

                    // Frame pulses seen here are deliberately dropped.
                    c_ST_SETTLE: begin
                        if (r_settle_cnt == c_SETTLE_LAST) begin
                            r_state <= c_ST_WAIT_FRAME;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end

                    c_ST_WAIT_FRAME: begin
                        if (i_frame_start) begin
                            r_state     <= c_ST_RUN;
                            r_tx_enable <= 1'b1;
                            r_link_up   <= 1'b1;
                        end
                    end

                    c_ST_RUN: begin
                        r_tx_enable <= 1'b1;
                        r_link_up   <= 1'b1;
                    end

                    default: begin
                        r_state       <= c_ST_IDLE;
                        r_rst_oserdes <= 1'b1;
                        r_tx_enable   <= 1'b0;
                        r_link_up     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rst_oserdes  = r_rst_oserdes;
    assign o_tx_enable    = r_tx_enable;
    assign o_link_up      = r_link_up;
    assign o_relock_count = r_relock_count;

endmodule : dvi_link_sequencer
`default_nettype wire

// File: tb/tb_dvi_link_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dvi_link_sequencer
//  Description : Directed self-checking bench for dvi_link_sequencer with
//                LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, SETTLE_CYCLES=6.
//                Inputs are driven and outputs sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dvi_link_sequencer;

    logic       clk;
    logic       rst;
    logic       mmcm_locked;
    logic       enable;
    logic       frame_start;
    logic       rst_oserdes;
    logic       tx_enable;
    logic       link_up;
    logic [7:0] relock_count;

    int vectors;
    int miscompares;

    dvi_link_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .RST_HOLD_CYCLES    (4),
        .SETTLE_CYCLES      (6)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mmcm_locked  (mmcm_locked),
        .i_enable       (enable),
        .i_frame_start  (frame_start),
        .o_rst_oserdes  (rst_oserdes),
        .o_tx_enable    (tx_enable),
        .o_link_up      (link_up),
        .o_relock_count (relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare {rst_oserdes, tx_enable, link_up}
    task automatic chk_out(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {rst_oserdes, tx_enable, link_up};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed {rst,tx,up}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] exp);
        vectors++;
        assert (relock_count === exp) else begin
            miscompares++;
            $error("FAIL %s observed relock_count=%0d expected=%0d", tag, relock_count, exp);
        end
    endtask

    // From IDLE with synchronized lock low and enable high: lock rises, RESET
    // at edge 11, SETTLE at 15, WAIT_FRAME at 21, pulse accepted at edge 22,
    // then lock falls and the link aborts 3 edges later.
    task automatic run_and_lose_lock();
        mmcm_locked = 1'b1;
        step(15);
        frame_start = 1'b1;
        step(7);
        frame_start = 1'b0;
        mmcm_locked = 1'b0;
        step(3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        mmcm_locked = 1'b0;
        enable      = 1'b0;
        frame_start = 1'b0;
        step(3);
        chk_out("reset_outputs", 3'b100);
        chk_cnt("reset_relock", 8'd0);
        rst = 1'b0;

        // ---- Bring-up: rst drops at edge 2+8+1+4 = 15 ----
        mmcm_locked = 1'b1;
        enable      = 1'b1;
        step(14);
        chk_out("bringup_rst_held_e14", 3'b100);
        step(1);
        chk_out("bringup_rst_release_e15", 3'b000);

        // ---- Pulse in last SETTLE cycle (edge 21) is ignored ----
        step(5);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        chk_out("settle_pulse_blanking_e21", 3'b000);
        step(1);
        chk_out("settle_pulse_ignored_e22", 3'b000);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        chk_out("run_after_second_pulse", 3'b011);

        // ---- Lock loss in RUN: 3-cycle latency, relock count 0->1 ----
        mmcm_locked = 1'b0;
        step(2);
        chk_out("lockloss_still_run_e2", 3'b011);
        step(1);
        chk_out("lockloss_abort_e3", 3'b100);
        chk_cnt("lockloss_relock_1", 8'd1);

        // ---- Full re-qualification before next RESET ----
        mmcm_locked = 1'b1;
        step(14);
        chk_out("requal_rst_held_e14", 3'b100);
        step(1);
        chk_out("requal_rst_release_e15", 3'b000);

        // ---- Enable dropped in SETTLE: IDLE next cycle ----
        step(1);
        enable = 1'b0;
        step(1);
        chk_out("en_drop_settle_abort", 3'b100);
        chk_cnt("en_drop_no_relock_inc", 8'd1);
        enable = 1'b1;
        // Counter cleared at abort edge E: RESET at E+9, release at E+13
        step(12);
        chk_out("en_requal_rst_held", 3'b100);
        step(1);
        chk_out("en_requal_rst_release", 3'b000);

        // ---- Back to RUN, then i_rst in RUN ----
        frame_start = 1'b1;
        step(7);
        frame_start = 1'b0;
        chk_out("run_before_rst", 3'b011);
        rst = 1'b1;
        step(1);
        chk_out("rst_in_run_outputs", 3'b100);
        chk_cnt("rst_in_run_relock_clear", 8'd0);
        rst         = 1'b0;
        mmcm_locked = 1'b0;
        step(3);

        // ---- One-cycle lock glitch during qualification ----
        mmcm_locked = 1'b1;
        step(5);
        mmcm_locked = 1'b0;
        step(1);
        mmcm_locked = 1'b1;
        step(14);
        chk_out("glitch_rst_held", 3'b100);
        step(1);
        chk_out("glitch_rst_release", 3'b000);

        // ---- Frame pulse coincident with enable drop in WAIT_FRAME ----
        step(6);
        enable      = 1'b0;
        frame_start = 1'b1;
        step(1);
        enable      = 1'b1;
        frame_start = 1'b0;
        chk_out("abort_beats_frame_start", 3'b100);
        mmcm_locked = 1'b0;
        step(3);

        // ---- 300 lock-loss aborts from RUN: count saturates at 255 ----
        for (int i = 0; i < 300; i++) begin
            run_and_lose_lock();
            if (i == 0)   chk_cnt("relock_first", 8'd1);
            if (i == 253) chk_cnt("relock_254", 8'd254);
            if (i == 254) chk_cnt("relock_255", 8'd255);
        end
        chk_cnt("relock_saturated", 8'd255);
        chk_out("after_sat_idle", 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dvi_link_sequencer
`default_nettype wire
